// File: rtl/status_display_ctrl.sv
// status_display_ctrl: login status FSM with lockout driving a multiplexed, blinking 7-segment display
module status_display_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 1000,
  parameter int BLINK_CYCLES   = 25000000,
  parameter int MAX_FAILS      = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [1:0]            WarningFlag,
  input  logic                  FlagValid,
  input  logic                  Clear,
  output logic [6:0]            SegOut,
  output logic [NUM_DIGITS-1:0] DigitEn,
  output logic                  Locked,
  output logic [3:0]            FailCount
);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(NUM_DIGITS - 1);
  localparam logic [3:0]    MAXF       = 4'(MAX_FAILS);
  localparam logic [6:0]    BLANK      = 7'b1111111;
  typedef enum logic [1:0] {IDLE, PASS, FAIL, LOCK} state_t;
  state_t state, stateNext;
  logic [3:0] failNext;
  logic [RW-1:0] refCnt;
  logic [SW-1:0] scanIdx;
  logic [BW-1:0] blinkCnt;
  logic blinkOn, failIn, blinking;
  logic [6:0] stateGlyph, countGlyph, segNext;
  function automatic logic [6:0] decGlyph(input logic [3:0] d);
    case (d)
      4'd0:    decGlyph = 7'b1000000;
      4'd1:    decGlyph = 7'b1111001;
      4'd2:    decGlyph = 7'b0100100;
      4'd3:    decGlyph = 7'b0110000;
      4'd4:    decGlyph = 7'b0011001;
      4'd5:    decGlyph = 7'b0010010;
      4'd6:    decGlyph = 7'b0000010;
      4'd7:    decGlyph = 7'b1111000;
      4'd8:    decGlyph = 7'b0000000;
      4'd9:    decGlyph = 7'b0010000;
      default: decGlyph = BLANK;
    endcase
  endfunction
  always_comb begin
    stateNext = state;
    failNext = FailCount;
    failIn = FlagValid && WarningFlag == 2'b01 && state != LOCK && !Clear;
    if (Clear) begin
      stateNext = IDLE;
      failNext = '0;
    end else if (FlagValid && state != LOCK) begin
      if (WarningFlag == 2'b01) begin
        failNext = FailCount + 4'd1;
        stateNext = failNext == MAXF ? LOCK : FAIL;
      end else if (WarningFlag == 2'b10) begin
        stateNext = PASS;
        failNext = '0;
      end else if (WarningFlag == 2'b11) begin
        stateNext = IDLE;
      end
    end
  end
  always_comb begin
    stateGlyph = state == IDLE ? 7'b1000000 : state == PASS ? 7'b0001100 :
                 state == FAIL ? 7'b0001110 : 7'b1000111;
    countGlyph = decGlyph(FailCount);
    blinking = (state == FAIL || state == LOCK) && !blinkOn;
    segNext = scanIdx == '0 ? (blinking ? BLANK : stateGlyph) :
              scanIdx == SW'(1) ? countGlyph : BLANK;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      FailCount <= '0;
      Locked <= 1'b0;
      refCnt <= '0;
      scanIdx <= '0;
      blinkCnt <= '0;
      blinkOn <= 1'b1;
      SegOut <= BLANK;
      DigitEn <= '1;
    end else begin
      state <= stateNext;
      FailCount <= failNext;
      Locked <= stateNext == LOCK;
      refCnt <= refCnt == REF_LAST ? '0 : refCnt + 1'b1;
      if (refCnt == REF_LAST) scanIdx <= scanIdx == SCAN_LAST ? '0 : scanIdx + 1'b1;
      // every fail acceptance restarts the blink on its visible phase
      if (failIn) begin
        blinkCnt <= '0;
        blinkOn <= 1'b1;
      end else if (state == FAIL || state == LOCK) begin
        blinkCnt <= blinkCnt == BLINK_LAST ? '0 : blinkCnt + 1'b1;
        if (blinkCnt == BLINK_LAST) blinkOn <= ~blinkOn;
      end else begin
        blinkCnt <= '0;
        blinkOn <= 1'b1;
      end
      SegOut <= segNext;
      DigitEn <= ~(NUM_DIGITS'(1) << scanIdx);
    end
  end
endmodule

// File: tb/tb_status_display_ctrl.sv
// tb_status_display_ctrl: vector table, corner sequences and random traffic against a behavioural model
module tb_status_display_ctrl;
  localparam int N = 4, R = 4, B = 8, MAXF = 3;
  localparam logic [6:0] SG [0:3] = '{7'b1000000, 7'b0001100, 7'b0001110, 7'b1000111};
  localparam logic [6:0] DG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [3:0] SCAN [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic Clock = 0, Reset = 0, FlagValid = 0, Clear = 0;
  logic [1:0] WarningFlag = 0;
  logic [6:0] SegOut;
  logic [N-1:0] DigitEn;
  logic Locked;
  logic [3:0] FailCount;
  int checks = 0, errors = 0;
  int ms = 0, mc = 0, mn = 0, me = 0;
  status_display_ctrl #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLINK_CYCLES(B), .MAX_FAILS(MAXF)) dut (
    .Clock(Clock), .Reset(Reset), .WarningFlag(WarningFlag), .FlagValid(FlagValid), .Clear(Clear),
    .SegOut(SegOut), .DigitEn(DigitEn), .Locked(Locked), .FailCount(FailCount));
  always #5 Clock = ~Clock;
  typedef struct {logic r, v; logic [1:0] f; logic c, lk; logic [3:0] fc;} vec_t;
  vec_t vt [0:13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [1:0] f, input logic c);
    logic [6:0] es;
    logic [N-1:0] ed;
    int idx;
    bit off;
    Reset = r; FlagValid = v; WarningFlag = f; Clear = c;
    if (r) begin
      es = 7'h7f;
      ed = '1;
    end else begin
      idx = (mn / R) % N;
      off = ms >= 2 && ((mn - me) / B) % 2 == 1;
      es = idx == 0 ? (off ? 7'h7f : SG[ms]) : idx == 1 ? DG[mc] : 7'h7f;
      ed = 4'b1111 ^ (4'b0001 << idx);
    end
    @(posedge Clock);
    if (r) begin
      ms = 0; mc = 0; mn = 0; me = 0;
    end else begin
      mn++;
      if (c) begin
        ms = 0; mc = 0;
      end else if (v && ms != 3) begin
        if (f == 2'b01) begin
          mc++;
          ms = mc == MAXF ? 3 : 2;
          me = mn;
        end else if (f == 2'b10) begin
          ms = 1; mc = 0;
        end else if (f == 2'b11) ms = 0;
      end
    end
    #1;
    chk("seg", 32'(SegOut), 32'(es));
    chk("digit_en", 32'(DigitEn), 32'(ed));
    chk("locked", 32'(Locked), 32'(ms == 3));
    chk("fail_count", 32'(FailCount), 32'(mc));
  endtask
  initial begin
    vt[0]  = '{1, 0, 2'b00, 0, 0, 0};
    vt[1]  = '{0, 1, 2'b01, 0, 0, 1};
    vt[2]  = '{0, 1, 2'b00, 0, 0, 1};
    vt[3]  = '{0, 1, 2'b11, 0, 0, 1};
    vt[4]  = '{0, 1, 2'b01, 0, 0, 2};
    vt[5]  = '{0, 1, 2'b01, 0, 1, 3};
    vt[6]  = '{0, 1, 2'b10, 0, 1, 3};
    vt[7]  = '{0, 1, 2'b01, 0, 1, 3};
    vt[8]  = '{0, 1, 2'b01, 1, 0, 0};
    vt[9]  = '{0, 1, 2'b01, 0, 0, 1};
    vt[10] = '{0, 1, 2'b10, 0, 0, 0};
    vt[11] = '{0, 0, 2'b01, 0, 0, 0};
    vt[12] = '{0, 1, 2'b01, 0, 0, 1};
    vt[13] = '{1, 1, 2'b01, 1, 0, 0};
    for (int i = 0; i < 14; i++) begin
      step(vt[i].r, vt[i].v, vt[i].f, vt[i].c);
      chk($sformatf("vec%0d_locked", i), 32'(Locked), 32'(vt[i].lk));
      chk($sformatf("vec%0d_count", i), 32'(FailCount), 32'(vt[i].fc));
    end
    step(1, 0, 2'b00, 0);
    chk("reset_seg", 32'(SegOut), 32'h7f);
    for (int n = 1; n <= 20; n++) begin
      step(0, 0, 2'b00, 0);
      if (n <= 16) chk("scan_seq", 32'(DigitEn), 32'(SCAN[(n - 1) / 4]));
      if (n >= 1 && n <= 4) chk("scan_d0_idle", 32'(SegOut), 32'h40);
    end
    step(1, 0, 2'b00, 0);
    step(0, 1, 2'b01, 0);
    step(0, 1, 2'b01, 0);
    for (int n = 0; n < 24; n++) step(0, 0, 2'b00, 0);
    chk("two_fails_count", 32'(FailCount), 32'd2);
    step(0, 1, 2'b01, 0);
    for (int n = 0; n < 20; n++) step(0, 0, 2'b00, 0);
    step(0, 1, 2'b10, 0);
    chk("lock_holds", 32'(Locked), 32'd1);
    step(0, 1, 2'b01, 1);
    chk("clear_unlocks", 32'(Locked), 32'd0);
    step(1, 0, 2'b00, 0);
    step(0, 1, 2'b01, 0);
    step(0, 1, 2'b10, 0);
    for (int n = 0; n < 7; n++) step(0, 0, 2'b00, 0);
    step(1, 0, 2'b00, 0);
    chk("mid_scan_reset_seg", 32'(SegOut), 32'h7f);
    chk("mid_scan_reset_en", 32'(DigitEn), 32'hf);
    for (int n = 0; n < 1500; n++)
      step($urandom_range(199) == 0, $urandom_range(2) == 0, 2'($urandom_range(3)), $urandom_range(39) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
